mem_stage_lsu: RTL

- Next-generation MEM pipeline stage for the in-order CPU. Sits between EXE and WB and uses the same valid/allow_in handshake as the other stages.
- Adds variable-latency load completion: it holds the instruction until the data-RAM response arrives and buffers that response when WB stalls.
- Extracts and extends load data by byte, half, word or doubleword, and selects the final register-file write data.
- Drives a forwarding/interlock port back to ID.

---
 rtl/mem_stage_lsu.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: holds loads until the data-RAM response arrives,
// buffers it across WB stalls, extracts/extends load data, drives bypass.
module mem_stage_lsu #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exe_to_mem_valid,
  output logic                 mem_allow_in,
  input  logic [PC_W-1:0]      exe_pc_plus_4,
  input  logic [DATA_W-1:0]    exe_alu_res,
  input  logic [RF_ADDR_W-1:0] exe_rf_waddr,
  input  logic                 exe_rf_we,
  input  logic [1:0]           exe_sel_rf_wdata,
  input  logic                 exe_mem_re,
  input  logic [2:0]           exe_load_op,
  input  logic [DATA_W-1:0]    data_rdata,
  input  logic                 data_rdata_ok,
  input  logic                 wb_allow_in,
  output logic                 mem_to_wb_valid,
  output logic [PC_W-1:0]      wb_pc_plus_4,
  output logic [RF_ADDR_W-1:0] wb_rf_waddr,
  output logic                 wb_rf_we,
  output logic [DATA_W-1:0]    wb_rf_wdata,
  output logic                 fwd_valid,
  output logic [RF_ADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0]    fwd_data,
  output logic                 fwd_pending
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam logic [OFF_W-1:0] HALF_M = ~(OFF_W'(1));
  localparam logic [OFF_W-1:0] WORD_M = ~(OFF_W'(3));

  typedef enum logic [1:0] {
    EMPTY,
    WAIT,
    READY
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]      pc_plus_4;
    logic [DATA_W-1:0]    alu_res;
    logic [RF_ADDR_W-1:0] rf_waddr;
    logic                 rf_we;
    logic [1:0]           sel;
    logic                 mem_re;
    logic [2:0]           load_op;
  } mem_inst_t;

  state_t            state;
  state_t            state_nxt;
  mem_inst_t         inst;
  logic [DATA_W-1:0] resp_buf;
  logic              buf_we;
  logic              mem_valid;
  logic              buf_valid;
  logic              ready_go;
  logic              accept;
  logic              take;

  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] sh;
  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  lane;
  logic [63:0]       sh64;
  logic [63:0]       ld64;
  logic [DATA_W-1:0] ld_data;

  // A held load in READY always owns valid buffered data.
  assign mem_valid = (state != EMPTY);
  assign buf_valid = (state == READY) & inst.mem_re;
  assign ready_go  = ~inst.mem_re | buf_valid | data_rdata_ok;

  assign mem_to_wb_valid = mem_valid & ready_go;
  assign mem_allow_in    = ~mem_valid | (wb_allow_in & ready_go);
  assign accept          = exe_to_mem_valid & mem_allow_in;
  assign take            = mem_to_wb_valid & wb_allow_in;

  always_comb begin
    state_nxt = state;
    buf_we    = 1'b0;
    if (accept) begin
      state_nxt = exe_mem_re ? WAIT : READY;
    end else if (take) begin
      state_nxt = EMPTY;
    end else if ((state == WAIT) && data_rdata_ok) begin
      state_nxt = READY;
      buf_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      inst     <= '0;
      resp_buf <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        inst.pc_plus_4 <= exe_pc_plus_4;
        inst.alu_res   <= exe_alu_res;
        inst.rf_waddr  <= exe_rf_waddr;
        inst.rf_we     <= exe_rf_we;
        inst.sel       <= exe_sel_rf_wdata;
        inst.mem_re    <= exe_mem_re;
        inst.load_op   <= exe_load_op;
      end
      if (buf_we) begin
        resp_buf <= data_rdata;
      end
    end
  end

  // Extraction is done in a 64-bit frame and truncated, so the 32-bit
  // build folds LWU/LD onto LW without width-specific branches.
  always_comb begin
    src = buf_valid ? resp_buf : data_rdata;
    off = inst.alu_res[OFF_W-1:0];
    case (inst.load_op)
      3'd0, 3'd1: lane = off;
      3'd2, 3'd3: lane = off & HALF_M;
      3'd6:       lane = (DATA_W == 64) ? '0 : (off & WORD_M);
      default:    lane = off & WORD_M;
    endcase
    sh   = src >> {lane, 3'b000};
    sh64 = 64'(sh);
    case (inst.load_op)
      3'd0:    ld64 = {{56{sh64[7]}}, sh64[7:0]};
      3'd1:    ld64 = {56'b0, sh64[7:0]};
      3'd2:    ld64 = {{48{sh64[15]}}, sh64[15:0]};
      3'd3:    ld64 = {48'b0, sh64[15:0]};
      3'd5:    ld64 = {32'b0, sh64[31:0]};
      3'd6:    ld64 = sh64;
      default: ld64 = {{32{sh64[31]}}, sh64[31:0]};
    endcase
    ld_data = DATA_W'(ld64);
  end

  always_comb begin
    wb_rf_wdata = inst.alu_res;
    unique case (inst.sel)
      2'd1:    wb_rf_wdata = ld_data;
      2'd2:    wb_rf_wdata = DATA_W'(inst.pc_plus_4);
      default: wb_rf_wdata = inst.alu_res;
    endcase
  end

  assign wb_pc_plus_4 = inst.pc_plus_4;
  assign wb_rf_waddr  = inst.rf_waddr;
  assign wb_rf_we     = inst.rf_we;

  assign fwd_valid   = mem_valid & inst.rf_we & (inst.rf_waddr != '0);
  assign fwd_waddr   = inst.rf_waddr;
  assign fwd_data    = wb_rf_wdata;
  assign fwd_pending = fwd_valid & inst.mem_re & ~buf_valid & ~data_rdata_ok;

endmodule
